// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and downstream memory port signals shared by mem_port_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_valid;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_req_ready;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_rdata;

    logic                  lsu_req_valid;
    logic                  lsu_req_write;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wstrb;
    logic                  lsu_req_ready;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_rdata;

    logic                  m_req_valid;
    logic                  m_req_ready;
    logic                  m_req_write;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_resp_valid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_req_write, lsu_addr, lsu_wdata, lsu_wstrb,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output m_req_valid, m_req_write, m_addr, m_wdata, m_wstrb,
        input  m_req_ready, m_resp_valid, m_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_req_write, lsu_addr, lsu_wdata, lsu_wstrb,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  m_req_valid, m_req_write, m_addr, m_wdata, m_wstrb,
        output m_req_ready, m_resp_valid, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU fetches and LSU loads/stores.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise the LSU has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t              state, state_next;
    owner_t              owner;
    logic                grant_ifu, grant_lsu;
    logic                lsu_wins;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;
    logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
    logic                ifu_resp_q, lsu_resp_q;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;
    // On a tie the requester that did not win last time gets the port.
    assign lsu_wins = bus.lsu_req_valid && (!bus.ifu_req_valid || last_grant == OWN_IFU);
`else
    assign lsu_wins = bus.lsu_req_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_ifu  = 1'b0;
        grant_lsu  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
                    grant_lsu  = lsu_wins;
                    grant_ifu  = !lsu_wins;
                    state_next = REQ;
                end
            end
            REQ:     if (bus.m_req_ready)  state_next = RESP;
            RESP:    if (bus.m_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IFU;
            req_write   <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= OWN_IFU;
`endif
        end else begin
            ifu_resp_q <= 1'b0;
            lsu_resp_q <= 1'b0;
            if (grant_lsu) begin
                owner     <= OWN_LSU;
                req_write <= bus.lsu_req_write;
                req_addr  <= bus.lsu_addr;
                req_wdata <= bus.lsu_wdata;
                req_wstrb <= bus.lsu_wstrb;
            end else if (grant_ifu) begin
                owner     <= OWN_IFU;
                req_write <= 1'b0;
                req_addr  <= bus.ifu_addr;
                req_wdata <= '0;
                req_wstrb <= '0;
            end
`ifdef MEM_ARB_RR_EN
            if (grant_lsu)      last_grant <= OWN_LSU;
            else if (grant_ifu) last_grant <= OWN_IFU;
`endif
            // Stores only acknowledge; they must not disturb the last load data.
            if (state == RESP && bus.m_resp_valid) begin
                if (owner == OWN_IFU) begin
                    ifu_rdata_q <= bus.m_rdata;
                    ifu_resp_q  <= 1'b1;
                end else begin
                    if (!req_write) lsu_rdata_q <= bus.m_rdata;
                    lsu_resp_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.ifu_resp_valid = ifu_resp_q;
    assign bus.lsu_resp_valid = lsu_resp_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.m_req_valid    = (state == REQ);
    assign bus.m_req_write    = req_write;
    assign bus.m_addr         = req_addr;
    assign bus.m_wdata        = req_wdata;
    assign bus.m_wstrb        = req_wstrb;
endmodule
